// File: rtl/vga_pkg.sv
// Shared constants, command codes, FSM states and the glyph palette
// used by the VGA banner controller.
package vga_pkg;

  localparam int H_VALID_DEF = 640;
  localparam int V_VALID_DEF = 480;

  localparam logic [15:0] RGB_YELLOW = 16'hFFE0;
  localparam logic [15:0] RGB_RED    = 16'hF800;
  localparam logic [15:0] RGB_ORANGE = 16'hFC00;
  localparam logic [15:0] RGB_GREEN  = 16'h07E0;
  localparam logic [15:0] RGB_CYAN   = 16'h07FF;
  localparam logic [15:0] RGB_PURPLE = 16'hF81F;
  localparam logic [15:0] RGB_WHITE  = 16'hFFFF;
  localparam logic [15:0] RGB_GRAY   = 16'h8410;
  localparam logic [15:0] RGB_BLUE   = 16'h001F;

  localparam logic [1:0] CMD_PAUSE = 2'd0;
  localparam logic [1:0] CMD_RUN   = 2'd1;
  localparam logic [1:0] CMD_STEP  = 2'd2;
  localparam logic [1:0] CMD_HOME  = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_COMMIT = 2'd2
  } state_e;

  // Glyph colour sequence stepped through on every bounce.
  function automatic logic [15:0] palette_color(input logic [2:0] idx);
    logic [15:0] color;
    color = RGB_YELLOW;
    case (idx)
      3'd0: color = RGB_YELLOW;
      3'd1: color = RGB_RED;
      3'd2: color = RGB_ORANGE;
      3'd3: color = RGB_GREEN;
      3'd4: color = RGB_CYAN;
      3'd5: color = RGB_PURPLE;
      3'd6: color = RGB_WHITE;
      3'd7: color = RGB_GRAY;
      default: color = RGB_YELLOW;
    endcase
    return color;
  endfunction

endpackage

// File: rtl/banner_axis_step.sv
// One-axis bounce step: advances a position by STEP in the current direction,
// clamping to [0, MAX] and flipping direction when a boundary is reached.
module banner_axis_step #(
  parameter int MAX  = 576,
  parameter int STEP = 4
) (
  input  logic [9:0] pos,
  input  logic       dir,
  output logic [9:0] next_pos,
  output logic       next_dir,
  output logic       bounce
);

  logic [10:0] pos_ext;
  logic [10:0] sum;

  assign pos_ext = {1'b0, pos};
  assign sum     = pos_ext + 11'(STEP);

  // dir == 0 means increasing; touching the limit exactly still bounces.
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    bounce   = 1'b0;
    if (!dir) begin
      if (sum >= 11'(MAX)) begin
        next_pos = 10'(MAX);
        next_dir = 1'b1;
        bounce   = 1'b1;
      end else begin
        next_pos = sum[9:0];
      end
    end else begin
      if (pos_ext <= 11'(STEP)) begin
        next_pos = 10'd0;
        next_dir = 1'b0;
        bounce   = 1'b1;
      end else begin
        next_pos = pos - 10'(STEP);
      end
    end
  end

endmodule

// File: rtl/vga_banner_ctrl.sv
// Frame-synchronous banner motion and colour scheduler; all updates are
// taken right after the last active pixel so they land in blanking.
module vga_banner_ctrl
  import vga_pkg::*;
#(
  parameter int H_VALID   = H_VALID_DEF,
  parameter int V_VALID   = V_VALID_DEF,
  parameter int BANNER_W  = 64,
  parameter int BANNER_H  = 16,
  parameter int STEP_X    = 4,
  parameter int STEP_Y    = 2,
  parameter int FRAME_DIV = 1
) (
  input  logic        vga_clk,
  input  logic        sys_rst_n,
  input  logic [9:0]  pix_x,
  input  logic [9:0]  pix_y,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_code,
  output logic        cmd_ready,
  output logic [9:0]  banner_x,
  output logic [9:0]  banner_y,
  output logic [15:0] fg_color,
  output logic [15:0] bg_color,
  output logic        running,
  output logic        update_pulse
);

  localparam int XMAX = H_VALID - BANNER_W;
  localparam int YMAX = V_VALID - BANNER_H;
  localparam logic [9:0] LAST_X   = 10'(H_VALID - 1);
  localparam logic [9:0] LAST_Y   = 10'(V_VALID - 1);
  localparam logic [9:0] HOME_X   = 10'(XMAX / 2);
  localparam logic [9:0] HOME_Y   = 10'(YMAX / 2);
  localparam logic [7:0] DIV_LAST = 8'(FRAME_DIV - 1);

  state_e      state_q, state_d;
  logic        pend_valid_q, pend_valid_d;
  logic [1:0]  pend_code_q, pend_code_d;
  logic [9:0]  x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        dir_x_q, dir_x_d;
  logic        dir_y_q, dir_y_d;
  logic [2:0]  pal_q, pal_d;
  logic        run_q, run_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        frame_tick;
  logic        cmd_accept;
  logic        do_move;
  logic        run_eff;
  logic [9:0]  step_x_pos, step_y_pos;
  logic        step_x_dir, step_y_dir;
  logic        bounce_x, bounce_y;

  assign frame_tick = (pix_x == LAST_X) && (pix_y == LAST_Y);
  assign cmd_ready  = (state_q == S_IDLE) && !pend_valid_q;
  assign cmd_accept = cmd_valid && cmd_ready;

  banner_axis_step #(
    .MAX  (XMAX),
    .STEP (STEP_X)
  ) u_axis_x (
    .pos      (x_q),
    .dir      (dir_x_q),
    .next_pos (step_x_pos),
    .next_dir (step_x_dir),
    .bounce   (bounce_x)
  );

  banner_axis_step #(
    .MAX  (YMAX),
    .STEP (STEP_Y)
  ) u_axis_y (
    .pos      (y_q),
    .dir      (dir_y_q),
    .next_pos (step_y_pos),
    .next_dir (step_y_dir),
    .bounce   (bounce_y)
  );

  // The new picture is loaded as the FSM enters S_COMMIT, so it becomes
  // visible together with update_pulse two cycles after frame_tick.
  always_comb begin
    state_d      = state_q;
    pend_valid_d = pend_valid_q;
    pend_code_d  = pend_code_q;
    x_d          = x_q;
    y_d          = y_q;
    dir_x_d      = dir_x_q;
    dir_y_d      = dir_y_q;
    pal_d        = pal_q;
    run_d        = run_q;
    cnt_d        = cnt_q;
    do_move      = 1'b0;
    run_eff      = run_q;

    if (cmd_accept) begin
      pend_valid_d = 1'b1;
      pend_code_d  = cmd_code;
    end

    case (state_q)
      S_IDLE: begin
        if (frame_tick) state_d = S_CALC;
      end
      S_CALC: begin
        state_d = S_COMMIT;
        if (pend_valid_q && (pend_code_q == CMD_HOME)) begin
          x_d     = HOME_X;
          y_d     = HOME_Y;
          dir_x_d = 1'b0;
          dir_y_d = 1'b0;
          pal_d   = 3'd0;
          cnt_d   = 8'd0;
        end else if (pend_valid_q && (pend_code_q == CMD_STEP)) begin
          do_move = 1'b1;
          cnt_d   = 8'd0;
        end else begin
          if (pend_valid_q && (pend_code_q == CMD_PAUSE)) run_eff = 1'b0;
          if (pend_valid_q && (pend_code_q == CMD_RUN))   run_eff = 1'b1;
          run_d = run_eff;
          if (run_eff) begin
            if (cnt_q == DIV_LAST) begin
              do_move = 1'b1;
              cnt_d   = 8'd0;
            end else begin
              cnt_d = cnt_q + 8'd1;
            end
          end
        end

        if (do_move) begin
          x_d     = step_x_pos;
          y_d     = step_y_pos;
          dir_x_d = step_x_dir;
          dir_y_d = step_y_dir;
          if (bounce_x || bounce_y) pal_d = pal_q + 3'd1;
        end
      end
      S_COMMIT: begin
        state_d      = S_IDLE;
        pend_valid_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= S_IDLE;
      pend_valid_q <= 1'b0;
      pend_code_q  <= CMD_PAUSE;
      x_q          <= HOME_X;
      y_q          <= HOME_Y;
      dir_x_q      <= 1'b0;
      dir_y_q      <= 1'b0;
      pal_q        <= 3'd0;
      run_q        <= 1'b1;
      cnt_q        <= 8'd0;
    end else begin
      state_q      <= state_d;
      pend_valid_q <= pend_valid_d;
      pend_code_q  <= pend_code_d;
      x_q          <= x_d;
      y_q          <= y_d;
      dir_x_q      <= dir_x_d;
      dir_y_q      <= dir_y_d;
      pal_q        <= pal_d;
      run_q        <= run_d;
      cnt_q        <= cnt_d;
    end
  end

  assign banner_x     = x_q;
  assign banner_y     = y_q;
  assign fg_color     = palette_color(pal_q);
  assign bg_color     = RGB_BLUE;
  assign running      = run_q;
  assign update_pulse = (state_q == S_COMMIT);

endmodule

// File: tb/tb_vga_banner_ctrl.sv
// Self-checking bench for vga_banner_ctrl: a frame-level behavioural model
// is compared against the DUT on every negative clock edge.
module tb_vga_banner_ctrl;

  localparam logic [1:0] C_PAUSE = 2'd0;
  localparam logic [1:0] C_RUN   = 2'd1;
  localparam logic [1:0] C_STEP  = 2'd2;
  localparam logic [1:0] C_HOME  = 2'd3;

  logic        vga_clk   = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [9:0]  pix_x     = '0;
  logic [9:0]  pix_y     = '0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_code  = '0;

  logic        cmd_ready, running, update_pulse;
  logic [9:0]  banner_x, banner_y;
  logic [15:0] fg_color, bg_color;

  logic        c_ready, c_run, c_pulse;
  logic [9:0]  c_x, c_y;
  logic [15:0] c_fg, c_bg;

  int nVec = 0;
  int nMis = 0;

  logic [15:0] palTab [0:7] = '{16'hFFE0, 16'hF800, 16'hFC00, 16'h07E0,
                                16'h07FF, 16'hF81F, 16'hFFFF, 16'h8410};

  // Model state: position, signed velocity per axis, palette, run state.
  int mx, my, mvx, mvy, mPal, mCnt, mCode, since;
  bit mRun, mPend;

  always #20 vga_clk = ~vga_clk;

  vga_banner_ctrl dut (
    .vga_clk      (vga_clk),
    .sys_rst_n    (sys_rst_n),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_ready    (cmd_ready),
    .banner_x     (banner_x),
    .banner_y     (banner_y),
    .fg_color     (fg_color),
    .bg_color     (bg_color),
    .running      (running),
    .update_pulse (update_pulse)
  );

  // Tall banner so both axes hit their limits on the same move (72nd).
  vga_banner_ctrl #(.BANNER_H(192)) dutCorner (
    .vga_clk      (vga_clk),
    .sys_rst_n    (sys_rst_n),
    .pix_x        (pix_x),
    .pix_y        (pix_y),
    .cmd_valid    (cmd_valid),
    .cmd_code     (cmd_code),
    .cmd_ready    (c_ready),
    .banner_x     (c_x),
    .banner_y     (c_y),
    .fg_color     (c_fg),
    .bg_color     (c_bg),
    .running      (c_run),
    .update_pulse (c_pulse)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    mx = 288; my = 232; mvx = 4; mvy = 2;
    mPal = 0; mCnt = 0; mRun = 1'b1; mPend = 1'b0; mCode = 0; since = 0;
  endtask

  task automatic modelMove();
    int nx, ny;
    bit b;
    nx = mx + mvx;
    ny = my + mvy;
    b  = 1'b0;
    if (nx >= 576) begin nx = 576; mvx = -mvx; b = 1'b1; end
    else if (nx <= 0) begin nx = 0; mvx = -mvx; b = 1'b1; end
    if (ny >= 464) begin ny = 464; mvy = -mvy; b = 1'b1; end
    else if (ny <= 0) begin ny = 0; mvy = -mvy; b = 1'b1; end
    mx = nx;
    my = ny;
    if (b) mPal = (mPal + 1) % 8;
  endtask

  task automatic modelFrame();
    if (mPend && mCode == 3) begin
      mx = 288; my = 232; mvx = 4; mvy = 2; mPal = 0; mCnt = 0;
    end else if (mPend && mCode == 2) begin
      modelMove();
      mCnt = 0;
    end else begin
      if (mPend && mCode == 0) mRun = 1'b0;
      if (mPend && mCode == 1) mRun = 1'b1;
      if (mRun) begin
        mCnt++;
        if (mCnt == 1) begin
          modelMove();
          mCnt = 0;
        end
      end
    end
  endtask

  initial modelReset();

  // since: 0 = waiting for a frame, 1 = tick seen, 2 = update on display.
  always @(posedge vga_clk or negedge sys_rst_n) begin : modelProc
    bit tick, rdy;
    if (!sys_rst_n) begin
      modelReset();
    end else begin
      tick = (pix_x == 10'd639) && (pix_y == 10'd479);
      rdy  = (since == 0) && !mPend;
      if (cmd_valid && rdy) begin
        mPend = 1'b1;
        mCode = int'(cmd_code);
      end
      case (since)
        0: if (tick) since = 1;
        1: begin modelFrame(); since = 2; end
        default: begin mPend = 1'b0; since = 0; end
      endcase
    end
  end

  always @(negedge vga_clk) begin
    checkOutput("banner_x", 32'(banner_x), 32'(mx));
    checkOutput("banner_y", 32'(banner_y), 32'(my));
    checkOutput("fg_color", 32'(fg_color), 32'(palTab[mPal]));
    checkOutput("bg_color", 32'(bg_color), 32'h001F);
    checkOutput("running", 32'(running), 32'(mRun));
    checkOutput("update_pulse", 32'(update_pulse), 32'(since == 2));
    checkOutput("cmd_ready", 32'(cmd_ready), 32'((since == 0) && !mPend));
  end

  task automatic applyStimulus(input logic [9:0] px, input logic [9:0] py,
                               input logic v, input logic [1:0] code);
    @(posedge vga_clk);
    #1;
    pix_x     = px;
    pix_y     = py;
    cmd_valid = v;
    cmd_code  = code;
  endtask

  task automatic randPix(output logic [9:0] px, output logic [9:0] py);
    px = 10'($urandom_range(0, 799));
    if ($urandom_range(0, 3) == 0) px = 10'd639;
    py = 10'($urandom_range(0, 524));
    if (px == 10'd639 && py == 10'd479) py = 10'd478;
  endtask

  task automatic applyIdle();
    logic [9:0] px, py;
    randPix(px, py);
    applyStimulus(px, py, 1'b0, 2'd0);
  endtask

  task automatic tickFrame();
    applyStimulus(10'd639, 10'd479, 1'b0, 2'd0);
    repeat (4) applyIdle();
  endtask

  task automatic doReset();
    sys_rst_n = 1'b0;
    repeat (3) applyIdle();
    sys_rst_n = 1'b1;
    applyIdle();
  endtask

  task automatic sendCmd(input logic [1:0] code);
    logic [9:0] px, py;
    int n;
    n = 0;
    randPix(px, py);
    applyStimulus(px, py, 1'b1, code);
    while (!cmd_ready && n < 20) begin
      randPix(px, py);
      applyStimulus(px, py, 1'b1, code);
      n++;
    end
    checkOutput("cmd_accept_wait", 32'(cmd_ready), 32'd1);
    applyIdle();
  endtask

  initial begin
    #5ms;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [9:0] px, py;
    sys_rst_n = 1'b0;
    repeat (3) applyIdle();
    checkOutput("rst_x", 32'(banner_x), 32'd288);
    checkOutput("rst_y", 32'(banner_y), 32'd232);
    checkOutput("rst_fg", 32'(fg_color), 32'hFFE0);
    checkOutput("rst_bg", 32'(bg_color), 32'h001F);
    checkOutput("rst_run", 32'(running), 32'd1);
    checkOutput("rst_pulse", 32'(update_pulse), 32'd0);
    sys_rst_n = 1'b1;
    applyIdle();

    $display("[TB] first frame latency");
    applyStimulus(10'd639, 10'd479, 1'b0, 2'd0);
    applyIdle();
    checkOutput("lat_hold_x", 32'(banner_x), 32'd288);
    applyIdle();
    checkOutput("lat_x", 32'(banner_x), 32'd292);
    checkOutput("lat_y", 32'(banner_y), 32'd234);
    checkOutput("lat_pulse", 32'(update_pulse), 32'd1);
    checkOutput("lat_fg", 32'(fg_color), 32'hFFE0);
    applyIdle();
    checkOutput("lat_pulse_end", 32'(update_pulse), 32'd0);

    $display("[TB] right-edge bounce and corner bounce");
    doReset();
    repeat (71) tickFrame();
    checkOutput("corner_pre_fg", 32'(c_fg), 32'hFFE0);
    tickFrame();
    checkOutput("edge_x", 32'(banner_x), 32'd576);
    checkOutput("edge_y", 32'(banner_y), 32'd376);
    checkOutput("edge_fg", 32'(fg_color), 32'hF800);
    checkOutput("corner_x", 32'(c_x), 32'd576);
    checkOutput("corner_y", 32'(c_y), 32'd288);
    checkOutput("corner_fg", 32'(c_fg), 32'hF800);
    checkOutput("corner_bg", 32'(c_bg), 32'h001F);
    checkOutput("corner_run", 32'(c_run), 32'd1);
    checkOutput("corner_pulse", 32'(c_pulse), 32'd0);
    checkOutput("corner_ready", 32'(c_ready), 32'd1);
    tickFrame();
    checkOutput("edge_back_x", 32'(banner_x), 32'd572);
    checkOutput("edge_back_y", 32'(banner_y), 32'd378);
    checkOutput("corner_back_x", 32'(c_x), 32'd572);
    checkOutput("corner_back_y", 32'(c_y), 32'd286);

    $display("[TB] pause / step / home / run");
    doReset();
    repeat (5) tickFrame();
    sendCmd(C_PAUSE);
    repeat (3) tickFrame();
    checkOutput("pause_x", 32'(banner_x), 32'd308);
    checkOutput("pause_y", 32'(banner_y), 32'd242);
    checkOutput("pause_run", 32'(running), 32'd0);
    sendCmd(C_STEP);
    tickFrame();
    checkOutput("step_x", 32'(banner_x), 32'd312);
    checkOutput("step_y", 32'(banner_y), 32'd244);
    checkOutput("step_run", 32'(running), 32'd0);
    sendCmd(C_HOME);
    tickFrame();
    checkOutput("home_x", 32'(banner_x), 32'd288);
    checkOutput("home_y", 32'(banner_y), 32'd232);
    checkOutput("home_fg", 32'(fg_color), 32'hFFE0);
    sendCmd(C_RUN);
    tickFrame();
    checkOutput("run_x", 32'(banner_x), 32'd292);
    checkOutput("run_y", 32'(banner_y), 32'd234);
    checkOutput("run_run", 32'(running), 32'd1);

    $display("[TB] command backpressure");
    randPix(px, py);
    applyStimulus(px, py, 1'b1, C_PAUSE);
    checkOutput("bp_ready_first", 32'(cmd_ready), 32'd1);
    randPix(px, py);
    applyStimulus(px, py, 1'b1, C_RUN);
    checkOutput("bp_drop", 32'(cmd_ready), 32'd0);
    applyStimulus(10'd639, 10'd479, 1'b1, C_RUN);
    checkOutput("bp_hold", 32'(cmd_ready), 32'd0);
    randPix(px, py);
    applyStimulus(px, py, 1'b1, C_RUN);
    checkOutput("bp_calc", 32'(cmd_ready), 32'd0);
    randPix(px, py);
    applyStimulus(px, py, 1'b1, C_RUN);
    checkOutput("bp_commit_ready", 32'(cmd_ready), 32'd0);
    checkOutput("bp_commit_pulse", 32'(update_pulse), 32'd1);
    checkOutput("bp_commit_run", 32'(running), 32'd0);
    randPix(px, py);
    applyStimulus(px, py, 1'b1, C_RUN);
    checkOutput("bp_rise", 32'(cmd_ready), 32'd1);
    applyIdle();
    checkOutput("bp_second_pending", 32'(cmd_ready), 32'd0);
    tickFrame();
    checkOutput("bp_run", 32'(running), 32'd1);
    checkOutput("bp_x", 32'(banner_x), 32'd296);
    checkOutput("bp_y", 32'(banner_y), 32'd236);

    $display("[TB] reset during calculation");
    applyStimulus(10'd639, 10'd479, 1'b1, C_PAUSE);
    applyIdle();
    sys_rst_n = 1'b0;
    #1;
    checkOutput("rc_x", 32'(banner_x), 32'd288);
    checkOutput("rc_y", 32'(banner_y), 32'd232);
    checkOutput("rc_fg", 32'(fg_color), 32'hFFE0);
    checkOutput("rc_run", 32'(running), 32'd1);
    checkOutput("rc_pulse", 32'(update_pulse), 32'd0);
    checkOutput("rc_ready", 32'(cmd_ready), 32'd1);
    applyIdle();
    sys_rst_n = 1'b1;
    applyIdle();
    tickFrame();
    checkOutput("rc_after_x", 32'(banner_x), 32'd292);
    checkOutput("rc_after_run", 32'(running), 32'd1);

    $display("[TB] randomized frames");
    for (int f = 0; f < 500; f++) begin
      int gap;
      logic v;
      logic [1:0] code;
      int r;
      gap = $urandom_range(1, 6);
      applyStimulus(10'd639, 10'd479, 1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
      for (int g = 0; g < gap; g++) begin
        r = $urandom_range(0, 15);
        if (r == 0)      code = C_HOME;
        else if (r < 3)  code = C_PAUSE;
        else if (r < 6)  code = C_STEP;
        else             code = C_RUN;
        v = ($urandom_range(0, 3) == 0);
        randPix(px, py);
        applyStimulus(px, py, v, code);
      end
    end
    repeat (4) applyIdle();

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
